opponent_state_tracker: RTL

Parametrised successor to the single-opponent latch in the top level. Takes validated 44-bit opponent words from the Ethernet `receive` block, demultiplexes them by player ID into NUM_OPP per-opponent state slots, and suppresses duplicates. Tracks per-opponent link liveness with timeout counters. Publishes a frame-coherent, double-buffered copy of every slot to track_view, racer_view and forward_view at each frame start.

---
 rtl/opponent_state_tracker.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/opponent_state_tracker.sv
// -----------------------------------------------------------------------------
// opponent_state_tracker
//
// Purpose:
//   Takes validated opponent words from the Ethernet receive block and sorts
//   them by player ID into NUM_OPP per-opponent slots. Duplicate words are
//   suppressed. Each slot has a timeout counter that tracks link liveness.
//   At each frame start, a frame-coherent copy of every slot is published.
//
// Optional feature (macro OPP_STATS_EN):
//   When defined, adds pkt_count_out and drop_count_out. pkt_count_out counts
//   accepted words and wraps. drop_count_out counts dropped words and
//   saturates at 0xFFFF.
//
// Ports:
//   clk_in          system clock (eth_refclk domain)
//   rst_in          synchronous active-high reset
//   axiov_in        receive word valid
//   axiod_in        receive word; field positions:
//                     x[43:33] y[31:21] dir[19:11] game[7:5] reset[3] id[1:0]
//   frame_start_in  one-cycle pulse at the start of vertical blank
//   opp_x_out       published x per slot, slot k at [11k+10:11k]
//   opp_y_out       published y per slot, slot k at [11k+10:11k]
//   opp_dir_out     published direction per slot, slot k at [9k+8:9k]
//   opp_game_out    published game status per slot, slot k at [3k+2:3k]
//   opp_alive_out   live (not double-buffered) per-slot liveness
//   new_data_out    one-cycle per-slot pulse when a publish changed the slot
//   opp_reset_out   one-cycle pulse when an accepted word carries reset=1
//   pkt_count_out   (OPP_STATS_EN only) accepted-word count
//   drop_count_out  (OPP_STATS_EN only) dropped-word count
// -----------------------------------------------------------------------------
module opponent_state_tracker #(
    parameter int NUM_OPP     = 1,
    parameter int DATA_W      = 44,
    parameter int TIMEOUT_CYC = 2500000,
    parameter int CNT_W       = 22
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 axiov_in,
    input  logic [DATA_W-1:0]    axiod_in,
    input  logic                 frame_start_in,
    output logic [NUM_OPP*11-1:0] opp_x_out,
    output logic [NUM_OPP*11-1:0] opp_y_out,
    output logic [NUM_OPP*9-1:0]  opp_dir_out,
    output logic [NUM_OPP*3-1:0]  opp_game_out,
    output logic [NUM_OPP-1:0]    opp_alive_out,
    output logic [NUM_OPP-1:0]    new_data_out,
    output logic                  opp_reset_out
`ifdef OPP_STATS_EN
    ,
    output logic [15:0]           pkt_count_out,
    output logic [15:0]           drop_count_out
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       SLOT_LIMIT = 3'(NUM_OPP);

    logic [43:0]        word;
    logic               word_nonzero;
    logic [1:0]         word_id;
    logic               id_in_range;
    logic               accept;
    logic               word_rst;
    logic [NUM_OPP-1:0] slot_hit;
    logic [NUM_OPP-1:0] pub_change;

    logic [10:0]      work_x    [NUM_OPP];
    logic [10:0]      work_y    [NUM_OPP];
    logic [8:0]       work_dir  [NUM_OPP];
    logic [2:0]       work_game [NUM_OPP];
    logic [43:0]      last_word [NUM_OPP];
    logic [CNT_W-1:0] idle_cnt  [NUM_OPP];

    // Bits above 43 carry nothing for this block. They are folded into a
    // throwaway net so that wider receive words stay lint-quiet.
    generate
        if (DATA_W > 44) begin : g_wide_word
            logic unused_high_bits;
            assign unused_high_bits = ^axiod_in[DATA_W-1:44];
        end
    endgenerate

    // Decode the incoming word. An all-zero word is treated as "no data".
    // With a single opponent, the ID field is ignored so that any sender
    // lands in slot 0.
    assign word         = axiod_in[43:0];
    assign word_nonzero = (word != 44'd0);
    assign word_id      = (NUM_OPP > 1) ? word[1:0] : 2'd0;
    assign id_in_range  = ({1'b0, word_id} < SLOT_LIMIT);
    assign accept       = axiov_in && word_nonzero && id_in_range;
    assign word_rst     = word[3];

    // One-hot slot select for the accepted word, plus a per-slot flag
    // showing whether the working copy differs from what is currently
    // published.
    always_comb begin
        slot_hit   = '0;
        pub_change = '0;
        for (int k = 0; k < NUM_OPP; k++) begin
            slot_hit[k]   = accept && (word_id == 2'(k));
            pub_change[k] = ({work_x[k], work_y[k], work_dir[k], work_game[k]} !=
                             {opp_x_out[k*11 +: 11], opp_y_out[k*11 +: 11],
                              opp_dir_out[k*9 +: 9], opp_game_out[k*3 +: 3]});
        end
    end

    // Working slots. A reset-flagged word wipes the slot and its duplicate
    // filter. Otherwise, only a word that differs from the last one stored
    // reloads the fields. Repeats leave the slot untouched.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < NUM_OPP; k++) begin
                work_x[k]    <= '0;
                work_y[k]    <= '0;
                work_dir[k]  <= '0;
                work_game[k] <= '0;
                last_word[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OPP; k++) begin
                if (slot_hit[k]) begin
                    if (word_rst) begin
                        work_x[k]    <= '0;
                        work_y[k]    <= '0;
                        work_dir[k]  <= '0;
                        work_game[k] <= '0;
                        last_word[k] <= '0;
                    end else if (word != last_word[k]) begin
                        work_x[k]    <= word[43:33];
                        work_y[k]    <= word[31:21];
                        work_dir[k]  <= word[19:11];
                        work_game[k] <= word[7:5];
                        last_word[k] <= word;
                    end
                end
            end
        end
    end

    // Liveness. Any accepted word, duplicate or reset, refreshes the slot.
    // A live slot counts idle cycles. It dies when the counter has reached
    // its last value, and the counter then holds. Acceptance is checked
    // first, so it wins over a simultaneous expiry.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            opp_alive_out <= '0;
            for (int k = 0; k < NUM_OPP; k++) begin
                idle_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OPP; k++) begin
                if (slot_hit[k]) begin
                    idle_cnt[k]      <= '0;
                    opp_alive_out[k] <= 1'b1;
                end else if (opp_alive_out[k]) begin
                    if (idle_cnt[k] == CNT_LAST) begin
                        opp_alive_out[k] <= 1'b0;
                    end else begin
                        idle_cnt[k] <= idle_cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    // Publish. On a frame start, every working slot is copied out. Because
    // this samples the working registers before this edge's update, a word
    // that arrives together with frame_start waits for the next frame.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            opp_x_out    <= '0;
            opp_y_out    <= '0;
            opp_dir_out  <= '0;
            opp_game_out <= '0;
            new_data_out <= '0;
        end else begin
            new_data_out <= '0;
            if (frame_start_in) begin
                for (int k = 0; k < NUM_OPP; k++) begin
                    opp_x_out[k*11 +: 11] <= work_x[k];
                    opp_y_out[k*11 +: 11] <= work_y[k];
                    opp_dir_out[k*9 +: 9] <= work_dir[k];
                    opp_game_out[k*3 +: 3] <= work_game[k];
                    new_data_out[k]       <= pub_change[k];
                end
            end
        end
    end

    // Remote reset notification: one pulse per accepted reset-flagged word.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            opp_reset_out <= 1'b0;
        end else begin
            opp_reset_out <= accept && word_rst;
        end
    end

`ifdef OPP_STATS_EN
    // Link statistics. A valid cycle that is not accepted counts as a drop.
    // This covers both an all-zero word and an out-of-range ID.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pkt_count_out  <= '0;
            drop_count_out <= '0;
        end else begin
            if (accept) begin
                pkt_count_out <= pkt_count_out + 16'd1;
            end
            if (axiov_in && !accept && (drop_count_out != 16'hFFFF)) begin
                drop_count_out <= drop_count_out + 16'd1;
            end
        end
    end
`endif

endmodule
